// File: rtl/mcs51_xdata_arb.sv
// XDATA RAM arbiter, CPU (m0) vs DMA (m1): combinational grant, 1-cycle read return, losers wait holding req.
// CPU priority with DMA starvation guard and bounded DMA lock; define MCS51_XARB_STATS_EN for grant/conflict counters.
module mcs51_xdata_arb #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 8,
    parameter int LOCK_MAX     = 16
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_lock,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic [15:0]       stat_m0_grants,
    output logic [15:0]       stat_m1_grants,
    output logic [15:0]       stat_conflicts
);

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    localparam logic [7:0] STARVE_LIM8 = 8'(STARVE_LIMIT);
    localparam logic [7:0] LOCK_MAX8   = 8'(LOCK_MAX);

    state_t     state;
    logic [7:0] starve_cnt;
    logic [7:0] lock_cnt;
    logic       force_m0;
    logic       rvalid0_q;
    logic       rvalid1_q;

    // Grant decision; nothing is granted while reset is held.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (!reset) begin
            if (state == ST_LOCK) begin
                m1_gnt = m1_req;
            end else if (force_m0 && m0_req) begin
                m0_gnt = 1'b1;
            end else if (m1_req && (starve_cnt == STARVE_LIM8)) begin
                m1_gnt = 1'b1;
            end else if (m0_req) begin
                m0_gnt = 1'b1;
            end else if (m1_req) begin
                m1_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        mem_en    = m0_gnt | m1_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (m0_gnt) begin
            mem_we    = m0_we;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
        end else if (m1_gnt) begin
            mem_we    = m1_we;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_ARB;
            starve_cnt <= 8'd0;
            lock_cnt   <= 8'd0;
            force_m0   <= 1'b0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
        end else begin
            rvalid0_q <= m0_gnt && !m0_we;
            rvalid1_q <= m1_gnt && !m1_we;
            case (state)
                ST_ARB: begin
                    force_m0 <= 1'b0;
                    if (m1_gnt || !m1_req) begin
                        starve_cnt <= 8'd0;
                    end else if (starve_cnt < STARVE_LIM8) begin
                        starve_cnt <= starve_cnt + 8'd1;
                    end
                    // The decision right after a forced exit never re-enters the lock.
                    if (m1_gnt && m1_lock && !force_m0) begin
                        state    <= ST_LOCK;
                        lock_cnt <= 8'd1;
                    end
                end
                ST_LOCK: begin
                    if (!m1_lock || (lock_cnt >= LOCK_MAX8)) begin
                        state    <= ST_ARB;
                        lock_cnt <= 8'd0;
                        force_m0 <= m1_lock;
                    end else begin
                        lock_cnt <= lock_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= ST_ARB;
                end
            endcase
        end
    end

    // Read return is also gated by reset so a pending read never escapes.
    assign m0_rvalid = rvalid0_q && !reset;
    assign m1_rvalid = rvalid1_q && !reset;
    assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
    assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

`ifdef MCS51_XARB_STATS_EN
    logic [15:0] cnt_m0;
    logic [15:0] cnt_m1;
    logic [15:0] cnt_cf;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_m0 <= 16'd0;
            cnt_m1 <= 16'd0;
            cnt_cf <= 16'd0;
        end else begin
            if (m0_gnt && (cnt_m0 != 16'hFFFF)) begin
                cnt_m0 <= cnt_m0 + 16'd1;
            end
            if (m1_gnt && (cnt_m1 != 16'hFFFF)) begin
                cnt_m1 <= cnt_m1 + 16'd1;
            end
            if (m0_req && m1_req && (cnt_cf != 16'hFFFF)) begin
                cnt_cf <= cnt_cf + 16'd1;
            end
        end
    end

    assign stat_m0_grants = reset ? 16'd0 : cnt_m0;
    assign stat_m1_grants = reset ? 16'd0 : cnt_m1;
    assign stat_conflicts = reset ? 16'd0 : cnt_cf;
`else
    assign stat_m0_grants = 16'd0;
    assign stat_m1_grants = 16'd0;
    assign stat_conflicts = 16'd0;
`endif

endmodule

// File: tb/tb_mcs51_xdata_arb.sv
// Directed bench for mcs51_xdata_arb with a behavioural 64K x 8 synchronous RAM on the mem_* side.
module tb_mcs51_xdata_arb;

`ifdef MCS51_XARB_STATS_EN
    localparam int STAT_EXP = 1;
`else
    localparam int STAT_EXP = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [15:0] m0_addr = 16'h0;
    logic [7:0]  m0_wdata = 8'h0;
    logic        m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
    logic [15:0] m1_addr = 16'h0;
    logic [7:0]  m1_wdata = 8'h0;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [7:0]  m0_rdata, m1_rdata;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic [15:0] stat_m0_grants, stat_m1_grants, stat_conflicts;

    int   n_cmp = 0;
    int   n_bad = 0;
    logic pend0 = 1'b0;
    logic pend1 = 1'b0;

    logic [7:0] ram [0:65535];

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    mcs51_xdata_arb #(
        .ADDR_W(16), .DATA_W(8), .STARVE_LIMIT(8), .LOCK_MAX(16)
    ) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .stat_m0_grants(stat_m0_grants), .stat_m1_grants(stat_m1_grants),
        .stat_conflicts(stat_conflicts)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drv0(input logic req, input logic we, input logic [15:0] addr, input logic [7:0] wd);
        m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wd;
    endtask

    task automatic drv1(input logic req, input logic we, input logic [15:0] addr, input logic [7:0] wd,
                        input logic lock);
        m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wd; m1_lock = lock;
    endtask

    // Let combinational outputs settle, then confirm no request was withdrawn before its grant.
    task automatic settle();
        #1;
        n_cmp++;
        assert (!(pend0 && !m0_req) && !(pend1 && !m1_req)) else begin
            n_bad++;
            $error("FAIL req_held: observed m0_req=%0b m1_req=%0b expected pending requests still high",
                   m0_req, m1_req);
        end
        pend0 = m0_req && !m0_gnt && !reset;
        pend1 = m1_req && !m1_gnt && !reset;
    endtask

    initial begin
        // Reset: outputs forced low even with both requests raised.
        @(negedge clk);
        drv0(1'b1, 1'b0, 16'h0100, 8'h00);
        drv1(1'b1, 1'b0, 16'h0102, 8'h00, 1'b1);
        settle();
        chk("rst_m0_gnt", 32'(m0_gnt), 0);
        chk("rst_m1_gnt", 32'(m1_gnt), 0);
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_m0_rvalid", 32'(m0_rvalid), 0);
        chk("rst_m1_rvalid", 32'(m1_rvalid), 0);
        chk("rst_stat_m0", 32'(stat_m0_grants), 0);
        @(negedge clk);
        drv0(1'b0, 1'b0, 16'h0, 8'h0);
        drv1(1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
        reset = 1'b0;
        settle();

        // CPU-only traffic.
        @(negedge clk);
        drv0(1'b1, 1'b1, 16'h0100, 8'h1A);
        settle();
        chk("s1_wr_gnt", 32'(m0_gnt), 1);
        chk("s1_wr_m1_gnt", 32'(m1_gnt), 0);
        chk("s1_wr_mem_we", 32'(mem_we), 1);
        chk("s1_wr_mem_addr", 32'(mem_addr), 'h0100);
        chk("s1_wr_mem_wdata", 32'(mem_wdata), 'h1A);
        @(negedge clk);
        drv0(1'b1, 1'b0, 16'h0100, 8'h00);
        settle();
        chk("s1_rd_gnt", 32'(m0_gnt), 1);
        chk("s1_rd_mem_we", 32'(mem_we), 0);
        chk("s1_wr_no_rvalid", 32'(m0_rvalid), 0);
        @(negedge clk);
        drv0(1'b0, 1'b0, 16'h0, 8'h0);
        settle();
        chk("s1_rvalid", 32'(m0_rvalid), 1);
        chk("s1_rdata", 32'(m0_rdata), 'h1A);
        chk("s1_m1_rvalid", 32'(m1_rvalid), 0);
        chk("s1_idle_en", 32'(mem_en), 0);
        chk("s1_idle_addr", 32'(mem_addr), 0);
        @(negedge clk);
        drv0(1'b1, 1'b1, 16'h0101, 8'h10);
        settle();
        chk("s1_pre1_gnt", 32'(m0_gnt), 1);
        @(negedge clk);
        drv0(1'b1, 1'b1, 16'h0102, 8'h77);
        settle();
        chk("s1_pre2_gnt", 32'(m0_gnt), 1);
        @(negedge clk);
        drv0(1'b0, 1'b0, 16'h0, 8'h0);
        settle();
        chk("s1_rdata_idle", 32'(m0_rdata), 0);
        @(negedge clk);
        reset = 1'b1;
        settle();
        @(negedge clk);
        reset = 1'b0;
        settle();

        // Simultaneous reads: m0 wins cycle N, m1 follows in N+1.
        @(negedge clk);
        drv0(1'b1, 1'b0, 16'h0101, 8'h00);
        drv1(1'b1, 1'b0, 16'h0102, 8'h00, 1'b0);
        settle();
        chk("s2_n_m0_gnt", 32'(m0_gnt), 1);
        chk("s2_n_m1_gnt", 32'(m1_gnt), 0);
        chk("s2_n_addr", 32'(mem_addr), 'h0101);
        @(negedge clk);
        drv0(1'b0, 1'b0, 16'h0, 8'h0);
        settle();
        chk("s2_n1_m1_gnt", 32'(m1_gnt), 1);
        chk("s2_n1_m0_gnt", 32'(m0_gnt), 0);
        chk("s2_n1_addr", 32'(mem_addr), 'h0102);
        chk("s2_m0_rvalid", 32'(m0_rvalid), 1);
        chk("s2_m0_rdata", 32'(m0_rdata), 'h10);
        chk("s2_m1_rvalid_early", 32'(m1_rvalid), 0);
        @(negedge clk);
        drv1(1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
        settle();
        chk("s2_m1_rvalid", 32'(m1_rvalid), 1);
        chk("s2_m1_rdata", 32'(m1_rdata), 'h77);
        chk("s2_m0_rvalid_off", 32'(m0_rvalid), 0);
        chk("s2_m0_rdata_off", 32'(m0_rdata), 0);
        @(negedge clk);
        settle();
        chk("s2_stat_m0", 32'(stat_m0_grants), STAT_EXP);
        chk("s2_stat_m1", 32'(stat_m1_grants), STAT_EXP);
        chk("s2_stat_conf", 32'(stat_conflicts), STAT_EXP);

        // Starvation: m1 wins on the 9th cycle of its request.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drv0(1'b1, 1'b1, 16'h0200, 8'(i));
            drv1(1'b1, 1'b0, 16'h0101, 8'h00, 1'b0);
            settle();
            chk($sformatf("s3_m0_win%0d", i), 32'(m0_gnt), 1);
            chk($sformatf("s3_m1_wait%0d", i), 32'(m1_gnt), 0);
        end
        @(negedge clk);
        settle();
        chk("s3_m1_forced", 32'(m1_gnt), 1);
        chk("s3_m0_held", 32'(m0_gnt), 0);
        chk("s3_addr", 32'(mem_addr), 'h0101);
        @(negedge clk);
        drv1(1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
        settle();
        chk("s3_m0_resume", 32'(m0_gnt), 1);
        chk("s3_m1_rvalid", 32'(m1_rvalid), 1);
        chk("s3_m1_rdata", 32'(m1_rdata), 'h10);
        @(negedge clk);
        drv0(1'b0, 1'b0, 16'h0, 8'h0);
        settle();

        // Lock held for 4 writes, then released.
        @(negedge clk);
        drv1(1'b1, 1'b1, 16'h0300, 8'hA0, 1'b1);
        settle();
        chk("s4_lock_gnt0", 32'(m1_gnt), 1);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            drv0(1'b1, 1'b0, 16'h0100, 8'h00);
            drv1(1'b1, 1'b1, 16'h0300 + 16'(i), 8'hA0 + 8'(i), 1'b1);
            settle();
            chk($sformatf("s4_m1_gnt%0d", i), 32'(m1_gnt), 1);
            chk($sformatf("s4_m0_blk%0d", i), 32'(m0_gnt), 0);
        end
        @(negedge clk);
        drv1(1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
        settle();
        chk("s4_idle_m0_blk", 32'(m0_gnt), 0);
        chk("s4_idle_en", 32'(mem_en), 0);
        @(negedge clk);
        settle();
        chk("s4_m0_after", 32'(m0_gnt), 1);
        @(negedge clk);
        drv0(1'b0, 1'b0, 16'h0, 8'h0);
        settle();
        chk("s4_m0_rvalid", 32'(m0_rvalid), 1);
        chk("s4_m0_rdata", 32'(m0_rdata), 'h1A);

        // Lock held past LOCK_MAX: forced exit, m0 served first.
        @(negedge clk);
        drv1(1'b1, 1'b1, 16'h0500, 8'h00, 1'b1);
        settle();
        chk("s5_lock_gnt0", 32'(m1_gnt), 1);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            drv0(1'b1, 1'b1, 16'h0400, 8'h55);
            drv1(1'b1, 1'b1, 16'h0500 + 16'(i), 8'(i), 1'b1);
            settle();
            chk($sformatf("s5_m1_gnt%0d", i), 32'(m1_gnt), 1);
            chk($sformatf("s5_m0_blk%0d", i), 32'(m0_gnt), 0);
        end
        @(negedge clk);
        settle();
        chk("s5_force_m0", 32'(m0_gnt), 1);
        chk("s5_force_m1", 32'(m1_gnt), 0);
        chk("s5_force_addr", 32'(mem_addr), 'h0400);
        @(negedge clk);
        drv0(1'b0, 1'b0, 16'h0, 8'h0);
        drv1(1'b1, 1'b1, 16'h0520, 8'h66, 1'b0);
        settle();
        chk("s5_m1_after", 32'(m1_gnt), 1);
        @(negedge clk);
        drv0(1'b1, 1'b0, 16'h0400, 8'h00);
        drv1(1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
        settle();
        chk("s5_arb_m0", 32'(m0_gnt), 1);
        @(negedge clk);
        drv0(1'b0, 1'b0, 16'h0, 8'h0);
        settle();
        chk("s5_rd_rvalid", 32'(m0_rvalid), 1);
        chk("s5_rd_rdata", 32'(m0_rdata), 'h55);

        // Reset in the cycle after an m1 read grant.
        @(negedge clk);
        drv1(1'b1, 1'b0, 16'h0102, 8'h00, 1'b0);
        settle();
        chk("s6_m1_gnt", 32'(m1_gnt), 1);
        @(negedge clk);
        drv1(1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
        reset = 1'b1;
        settle();
        chk("s6_rst_m1_rvalid", 32'(m1_rvalid), 0);
        chk("s6_rst_m1_rdata", 32'(m1_rdata), 0);
        chk("s6_rst_mem_en", 32'(mem_en), 0);
        chk("s6_rst_stat_conf", 32'(stat_conflicts), 0);
        @(negedge clk);
        reset = 1'b0;
        settle();
        chk("s6_post_m1_rvalid", 32'(m1_rvalid), 0);
        chk("s6_post_stat_m0", 32'(stat_m0_grants), 0);
        chk("s6_post_stat_m1", 32'(stat_m1_grants), 0);
        @(negedge clk);
        drv0(1'b1, 1'b0, 16'h0101, 8'h00);
        drv1(1'b1, 1'b0, 16'h0102, 8'h00, 1'b1);
        settle();
        chk("s6_arb_m0", 32'(m0_gnt), 1);
        chk("s6_arb_m1", 32'(m1_gnt), 0);
        @(negedge clk);
        drv0(1'b0, 1'b0, 16'h0, 8'h0);
        settle();
        chk("s6_m1_gnt2", 32'(m1_gnt), 1);
        chk("s6_m0_rdata", 32'(m0_rdata), 'h10);
        @(negedge clk);
        drv1(1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
        settle();
        chk("s6_m1_rvalid", 32'(m1_rvalid), 1);
        chk("s6_m1_rdata", 32'(m1_rdata), 'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
